// File: rtl/reg_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_if
//  Description : Bundle of the M-to-W pipeline signals for the write-back
//                register stage.
//                master : drives the M-stage request and W-stage control,
//                         observes the W-stage results.
//                slave  : the reg_wb stage itself.
//  Parameters  : XLEN - datapath width (32 or 64)
//                RD_W - destination register index width
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  // W-stage pipeline control
  logic            stall_W;
  logic            flush_W;
  // M-stage request
  logic            valid_M;
  logic [XLEN-1:0] alu_out_M;
  logic [XLEN-1:0] ld_data_M;
  logic [2:0]      ld_funct3_M;
  logic            wb_sel_M;
  logic [RD_W-1:0] rd_M;
  logic            reg_we_M;
  // W-stage results
  logic            valid_W;
  logic [XLEN-1:0] wb_data_W;
  logic [RD_W-1:0] rd_W;
  logic            reg_we_W;
  logic [63:0]     instret_W;

  modport master (
    output stall_W, flush_W, valid_M, alu_out_M, ld_data_M, ld_funct3_M,
           wb_sel_M, rd_M, reg_we_M,
    input  valid_W, wb_data_W, rd_W, reg_we_W, instret_W
  );

  modport slave (
    input  stall_W, flush_W, valid_M, alu_out_M, ld_data_M, ld_funct3_M,
           wb_sel_M, rd_M, reg_we_M,
    output valid_W, wb_data_W, rd_W, reg_we_W, instret_W
  );
endinterface
`default_nettype wire

// File: rtl/reg_wb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb
//  Description : M-to-W pipeline register. Selects ALU result or extended
//                load data, suppresses x0 writes, supports stall and flush
//                (flush wins), and optionally counts retired instructions.
//  Ports       : clk  - clock, all state updates on rising edge
//                rst  - synchronous active-high reset
//                bus  - reg_wb_if.slave (M-stage inputs, W-stage outputs)
//  Parameters  : XLEN (32 or 64), RD_W
//  Macro       : REG_WB_INSTRET_EN - when defined, instret_W is a 64-bit
//                retired-instruction counter; otherwise it is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  reg_wb_if.slave  bus
);

  // Load funct3 encodings
  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LD  = 3'b011;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;
  localparam logic [2:0] c_LWU = 3'b110;

  logic [XLEN-1:0] ld_ext;

  // --------------------------------------------------------------------------
  // Load data extension. RV32 has no LD/LWU, and LW is already full width.
  // --------------------------------------------------------------------------
  generate
    if (XLEN == 64) begin : g_ext64
      always_comb begin
        ld_ext = '0;
        case (bus.ld_funct3_M)
          c_LB:    ld_ext = {{(XLEN-8){bus.ld_data_M[7]}},   bus.ld_data_M[7:0]};
          c_LH:    ld_ext = {{(XLEN-16){bus.ld_data_M[15]}}, bus.ld_data_M[15:0]};
          c_LW:    ld_ext = {{(XLEN-32){bus.ld_data_M[31]}}, bus.ld_data_M[31:0]};
          c_LD:    ld_ext = bus.ld_data_M;
          c_LBU:   ld_ext = {{(XLEN-8){1'b0}},  bus.ld_data_M[7:0]};
          c_LHU:   ld_ext = {{(XLEN-16){1'b0}}, bus.ld_data_M[15:0]};
          c_LWU:   ld_ext = {{(XLEN-32){1'b0}}, bus.ld_data_M[31:0]};
          default: ld_ext = '0;
        endcase
      end
    end else begin : g_ext32
      always_comb begin
        ld_ext = '0;
        case (bus.ld_funct3_M)
          c_LB:    ld_ext = {{(XLEN-8){bus.ld_data_M[7]}},   bus.ld_data_M[7:0]};
          c_LH:    ld_ext = {{(XLEN-16){bus.ld_data_M[15]}}, bus.ld_data_M[15:0]};
          c_LW:    ld_ext = bus.ld_data_M;
          c_LBU:   ld_ext = {{(XLEN-8){1'b0}},  bus.ld_data_M[7:0]};
          c_LHU:   ld_ext = {{(XLEN-16){1'b0}}, bus.ld_data_M[15:0]};
          default: ld_ext = '0;
        endcase
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // W-stage registers
  // --------------------------------------------------------------------------
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0] rd_q,      rd_d;
  logic            reg_we_q,  reg_we_d;

  always_comb begin
    valid_d   = valid_q;
    wb_data_d = wb_data_q;
    rd_d      = rd_q;
    reg_we_d  = reg_we_q;
    if (bus.flush_W) begin
      // Flush has priority over stall: the stage becomes an empty bubble.
      valid_d   = 1'b0;
      wb_data_d = '0;
      rd_d      = '0;
      reg_we_d  = 1'b0;
    end else if (!bus.stall_W) begin
      valid_d   = bus.valid_M;
      wb_data_d = bus.wb_sel_M ? ld_ext : bus.alu_out_M;
      rd_d      = bus.rd_M;
      // x0 is hardwired zero; never raise a write for it or for a bubble.
      reg_we_d  = bus.reg_we_M & bus.valid_M & (bus.rd_M != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wb_data_q <= '0;
      rd_q      <= '0;
      reg_we_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      reg_we_q  <= reg_we_d;
    end
  end

  assign bus.valid_W   = valid_q;
  assign bus.wb_data_W = wb_data_q;
  assign bus.rd_W      = rd_q;
  assign bus.reg_we_W  = reg_we_q;

  // --------------------------------------------------------------------------
  // Retired-instruction counter
  // --------------------------------------------------------------------------
`ifdef REG_WB_INSTRET_EN
  logic        capture;
  logic [63:0] instret_q, instret_d;

  assign capture = ~bus.flush_W & ~bus.stall_W;

  always_comb begin
    instret_d = instret_q;
    // Natural 64-bit wrap from all-ones back to zero.
    if (capture && bus.valid_M) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret_W = instret_q;
`else
  assign bus.instret_W = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb
//  Description : Self-checking bench for reg_wb (XLEN=64). Table of directed
//                vectors plus hand-written reset / counter sequences.
//                Honours REG_WB_INSTRET_EN for the expected instret_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb;
  localparam int XLEN = 64;
  localparam int RD_W = 5;
`ifdef REG_WB_INSTRET_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  reg_wb_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

  reg_wb #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_cnt = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic v, input logic [XLEN-1:0] d,
                           input logic [RD_W-1:0] r, input logic we, input logic [63:0] cnt);
    check({name, ".valid_W"},   64'(bus.valid_W),   64'(v));
    check({name, ".wb_data_W"}, 64'(bus.wb_data_W), 64'(d));
    check({name, ".rd_W"},      64'(bus.rd_W),      64'(r));
    check({name, ".reg_we_W"},  64'(bus.reg_we_W),  64'(we));
    check({name, ".instret_W"}, bus.instret_W,      cnt);
  endtask

  task automatic set_in(input logic stall, input logic flush, input logic valid,
                        input logic wbsel, input logic [2:0] f3, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] ld, input logic [RD_W-1:0] rd, input logic we);
    bus.stall_W     = stall;
    bus.flush_W     = flush;
    bus.valid_M     = valid;
    bus.wb_sel_M    = wbsel;
    bus.ld_funct3_M = f3;
    bus.alu_out_M   = alu;
    bus.ld_data_M   = ld;
    bus.rd_M        = rd;
    bus.reg_we_M    = we;
  endtask

  // Advance one edge; the expected counter advances on counted captures.
  task automatic tick;
    if (CNT_EN && !rst && !bus.flush_W && !bus.stall_W && bus.valid_M) exp_cnt = exp_cnt + 64'd1;
    if (rst) exp_cnt = 64'd0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string           name;
    logic            stall, flush, valid, wbsel, we;
    logic [2:0]      f3;
    logic [XLEN-1:0] alu, ld;
    logic [RD_W-1:0] rd;
    logic            e_valid, e_we;
    logic [XLEN-1:0] e_data;
    logic [RD_W-1:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic st, input logic fl, input logic v,
                     input logic ws, input logic [2:0] f3, input logic [XLEN-1:0] alu,
                     input logic [XLEN-1:0] ld, input logic [RD_W-1:0] rd, input logic we,
                     input logic ev, input logic [XLEN-1:0] ed, input logic [RD_W-1:0] er,
                     input logic ewe);
    vec_t t;
    t.name = n; t.stall = st; t.flush = fl; t.valid = v; t.wbsel = ws; t.f3 = f3;
    t.alu = alu; t.ld = ld; t.rd = rd; t.we = we;
    t.e_valid = ev; t.e_data = ed; t.e_rd = er; t.e_we = ewe;
    vecs.push_back(t);
  endtask

  initial begin
    //   name        st fl v ws f3      alu        ld                       rd we | ev data                     rd we
    add("lb_neg",    0, 0, 1, 1, 3'b000, 64'h0,    64'h80,                  1, 1,  1, 64'hFFFFFFFFFFFFFF80,     1, 1);
    add("lwu",       0, 0, 1, 1, 3'b110, 64'h0,    64'hFFFFFFFF80000000,    2, 1,  1, 64'h0000000080000000,     2, 1);
    add("f3_111",    0, 0, 1, 1, 3'b111, 64'h0,    64'hFFFFFFFF80000000,    2, 1,  1, 64'h0,                    2, 1);
    add("lh_neg",    0, 0, 1, 1, 3'b001, 64'h0,    64'h8001,                4, 1,  1, 64'hFFFFFFFFFFFF8001,     4, 1);
    add("lw_neg",    0, 0, 1, 1, 3'b010, 64'h0,    64'h80000000,            6, 0,  1, 64'hFFFFFFFF80000000,     6, 0);
    add("ld",        0, 0, 1, 1, 3'b011, 64'h0,    64'h123456789ABCDEF0,    7, 1,  1, 64'h123456789ABCDEF0,     7, 1);
    add("lbu",       0, 0, 1, 1, 3'b100, 64'h0,    64'hFFFFFFFFFFFFFFFF,    8, 1,  1, 64'h00000000000000FF,     8, 1);
    add("lhu",       0, 0, 1, 1, 3'b101, 64'h0,    64'hFFFF8000,            9, 1,  1, 64'h0000000000008000,     9, 1);
    add("x0_we",     0, 0, 1, 0, 3'b000, 64'hDEAD, 64'h77,                  0, 1,  1, 64'hDEAD,                 0, 0);
    add("rd5_we",    0, 0, 1, 0, 3'b000, 64'hBEEF, 64'h77,                  5, 1,  1, 64'hBEEF,                 5, 1);
    add("bubble",    0, 0, 0, 0, 3'b000, 64'h55,   64'h0,                   7, 1,  0, 64'h55,                   7, 0);
    add("alu_cap",   0, 0, 1, 0, 3'b000, 64'h1234, 64'h0,                   3, 1,  1, 64'h1234,                 3, 1);
    add("stall1",    1, 0, 1, 1, 3'b011, 64'h9999, 64'hAAAA,               9, 1,  1, 64'h1234,                 3, 1);
    add("stall2",    1, 0, 0, 0, 3'b000, 64'h8888, 64'h0,                  10, 0,  1, 64'h1234,                 3, 1);
    add("stall3",    1, 0, 1, 0, 3'b000, 64'h7777, 64'h0,                  11, 1,  1, 64'h1234,                 3, 1);
    add("stall_fl",  1, 1, 1, 0, 3'b000, 64'h6666, 64'h0,                  12, 1,  0, 64'h0,                    0, 0);

    // Reset with an instruction presented: it must be lost.
    rst = 1'b1;
    set_in(0, 0, 1, 0, 3'b000, 64'hCAFE, 64'h0, 5'd3, 1);
    tick();
    tick();
    check_all("reset", 0, '0, '0, 0, 64'd0);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].wbsel, vecs[i].f3,
             vecs[i].alu, vecs[i].ld, vecs[i].rd, vecs[i].we);
      tick();
      check_all(vecs[i].name, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_rd, vecs[i].e_we, exp_cnt);
      @(negedge clk);
    end

    // Reset while W holds a valid instruction and the counter is at 7.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 3'b000, 64'h0, 64'h0, 5'd0, 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      set_in(0, 0, 1, 0, 3'b000, 64'(k + 1), 64'h0, 5'd4, 1);
      tick();
      @(negedge clk);
    end
    check("pre_rst.valid_W", 64'(bus.valid_W), 64'd1);
    check("pre_rst.instret_W", bus.instret_W, CNT_EN ? 64'd7 : 64'd0);
    rst = 1'b1;
    set_in(1, 1, 1, 1, 3'b000, 64'h1, 64'h80, 5'd4, 1);
    tick();
    check_all("rst_override", 0, '0, '0, 0, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 10 counted captures, 2 stalled and 1 flushed cycle with valid_M high.
    for (int k = 0; k < 10; k++) begin
      set_in(0, 0, 1, 0, 3'b000, 64'h10 + 64'(k), 64'h0, 5'd1, 1);
      tick();
      @(negedge clk);
    end
    set_in(1, 0, 1, 0, 3'b000, 64'h0, 64'h0, 5'd1, 1);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    set_in(0, 1, 1, 0, 3'b000, 64'h0, 64'h0, 5'd1, 1);
    tick();
    check("count10.instret_W", bus.instret_W, CNT_EN ? 64'd10 : 64'd0);
    check("count10.model", bus.instret_W, exp_cnt);
    check("flush.valid_W", 64'(bus.valid_W), 64'd0);
    @(negedge clk);

`ifdef REG_WB_INSTRET_EN
    // Counter wrap: preload all-ones, then one capture.
    dut.instret_q = '1;
    set_in(0, 0, 1, 0, 3'b000, 64'h1, 64'h0, 5'd2, 1);
    @(posedge clk);
    #1;
    check("wrap.instret_W", bus.instret_W, 64'd0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter RD_W, default 5, destination-register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_W  input  1  hold all W-stage state this cycle.
REQ-006 flush_W  input  1  kill the instruction being captured into W.
REQ-007 valid_M  input  1  M stage holds a real instruction.
REQ-008 alu_out_M  input  XLEN  ALU result from M.
REQ-009 ld_data_M  input  XLEN  raw load data from M, already right-aligned to bit 0.
REQ-010 ld_funct3_M  input  3  load type: LB/LH/LW/LD/LBU/LHU/LWU encoding.
REQ-011 wb_sel_M  input  1  1 = write back load data, 0 = write back ALU result.
REQ-012 rd_M  input  RD_W  destination register index.
REQ-013 reg_we_M  input  1  instruction writes the register file.
REQ-014 valid_W  output  1  W stage holds a real instruction.
REQ-015 wb_data_W  output  XLEN  final register-file write data.
REQ-016 rd_W  output  RD_W  destination index.
REQ-017 reg_we_W  output  1  register-file write enable.
REQ-018 instret_W  output  64  retired-instruction count.

Function
REQ-019 The block SHALL be a one-stage register: accepted M inputs appear on W outputs exactly one cycle later.
REQ-020 An edge SHALL capture when rst=0, flush_W=0 and stall_W=0: valid_W<=valid_M, rd_W<=rd_M, wb_data_W<=selected data.
REQ-021 At a capture edge, reg_we_W SHALL be loaded with reg_we_M & valid_M & (rd_M != 0), so writes to x0 are suppressed.
REQ-022 Selected data SHALL be alu_out_M when wb_sel_M=0, otherwise ld_data_M extended per ld_funct3_M.
REQ-023 Extension: 000 sign-extends bits [7:0]; 001 sign-extends [15:0]; 010 sign-extends [31:0]; 011 passes [63:0]; 100 zero-extends [7:0]; 101 zero-extends [15:0]; 110 zero-extends [31:0]; 111 yields 0.
REQ-024 When XLEN=32, 010 SHALL pass [31:0] and 011/110/111 SHALL yield 0.
REQ-025 While stall_W=1 and flush_W=0, all outputs SHALL hold their values.
REQ-026 flush_W=1 SHALL override stall_W: next edge valid_W=0, reg_we_W=0, wb_data_W=0, rd_W=0.
REQ-027 No output SHALL have a combinational path from any input.

Reset
REQ-028 rst=1 at an edge SHALL clear valid_W, reg_we_W, wb_data_W, rd_W and instret_W to 0, overriding stall_W and flush_W.
REQ-029 An instruction being captured in a reset cycle SHALL be lost and SHALL NOT be counted.

Configuration
REQ-030 Macro REG_WB_INSTRET_EN defined: instret_W SHALL increment by 1 at every capture edge with valid_M=1, wrapping from 2^64-1 to 0.
REQ-031 Macro REG_WB_INSTRET_EN undefined: no counter state SHALL exist and instret_W SHALL be constant 0.

Verification
REQ-032 XLEN=64, wb_sel_M=1, ld_funct3_M=000, ld_data_M=0x80, valid_M=1 -> next cycle wb_data_W=0xFFFFFFFFFFFFFF80, valid_W=1.
REQ-033 ld_funct3_M=110, ld_data_M=0xFFFFFFFF80000000 -> wb_data_W=0x0000000080000000; ld_funct3_M=111 -> 0.
REQ-034 reg_we_M=1, valid_M=1, rd_M=0 -> reg_we_W=0; with rd_M=5 -> reg_we_W=1, rd_W=5.
REQ-035 Capture alu_out_M=0x1234, then 3 cycles stall_W=1 with new inputs -> wb_data_W stays 0x1234; assert stall_W=1 and flush_W=1 together -> valid_W=0, wb_data_W=0.
REQ-036 With REG_WB_INSTRET_EN defined, 10 valid captures, 2 stalled cycles, 1 flushed cycle -> instret_W=10; counter preloaded to 0xFFFFFFFFFFFFFFFF plus one capture -> 0.
REQ-037 rst=1 asserted while valid_W=1 and instret_W=7 -> next cycle all outputs 0.
